// File: rtl/envelope_follower.sv
// envelope_follower
// Streaming amplitude-envelope detector. Signed samples are rectified in stage 1;
// stage 2 maintains a 2^LOG2_DEPTH-tap running-sum average and a peak-hold/decay
// envelope side by side, and presents one of them on out_sample according to mode.
// One sample per cycle, no backpressure, two-edge latency from in_valid to out_valid.

module envelope_follower #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_DEPTH   = 3,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                    sample_clock,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    out_valid,
  output logic [SAMPLE_WIDTH-1:0] out_sample,
  output logic                    primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  // Sum of DEPTH unsigned W-bit magnitudes fits in W+LOG2_DEPTH bits.
  localparam int SUM_W = SAMPLE_WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX = DEPTH[LOG2_DEPTH:0];

  // Two's-complement magnitude; the most negative code maps to 2^(W-1) unsigned.
  function automatic logic [SAMPLE_WIDTH-1:0] rectify(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SAMPLE_WIDTH-1:0] r;
    if (s[SAMPLE_WIDTH-1]) begin
      r = ~s + SAMPLE_WIDTH'(1);
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Stage 1 state
  logic                    v1_q,  v1_d;
  logic [SAMPLE_WIDTH-1:0] mag_q, mag_d;

  // Stage 2 state
  logic [SAMPLE_WIDTH-1:0] buf_q [DEPTH];
  logic [SAMPLE_WIDTH-1:0] buf_d [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [SUM_W-1:0]        sum_q,        sum_d;
  logic [SAMPLE_WIDTH-1:0] peak_q,       peak_d;
  logic [LOG2_DEPTH:0]     fill_q,       fill_d;
  logic                    primed_q,     primed_d;
  logic [SAMPLE_WIDTH-1:0] out_sample_q, out_sample_d;
  logic                    out_valid_q,  out_valid_d;

  // Stage 2 intermediate values
  logic [SAMPLE_WIDTH-1:0] oldest_s;
  logic [SUM_W-1:0]        sum_next_s;
  logic [SAMPLE_WIDTH-1:0] decayed_s;
  logic [SAMPLE_WIDTH-1:0] peak_next_s;
  logic [SAMPLE_WIDTH-1:0] avg_s;

  // Stage 1 next state: capture the rectified sample; clear drops anything in flight.
  always_comb begin
    v1_d  = v1_q;
    mag_d = mag_q;
    if (clear) begin
      v1_d  = 1'b0;
      mag_d = '0;
    end else if (in_valid) begin
      v1_d  = 1'b1;
      mag_d = rectify(sample_in);
    end else begin
      v1_d  = 1'b0;
      mag_d = mag_q;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      mag_q <= '0;
    end else begin
      v1_q  <= v1_d;
      mag_q <= mag_d;
    end
  end

  // Stage 2 datapath: both envelopes are computed every accepted sample so a mode
  // switch only changes which one is presented, never the filter history.
  always_comb begin
    oldest_s    = buf_q[wr_ptr_q];
    sum_next_s  = sum_q + SUM_W'(mag_q) - SUM_W'(oldest_s);
    decayed_s   = peak_q - (peak_q >> DECAY_SHIFT);
    if (mag_q > decayed_s) begin
      peak_next_s = mag_q;
    end else begin
      peak_next_s = decayed_s;
    end
    // Floor division by the window length is just dropping the low bits.
    avg_s = sum_next_s[SUM_W-1:LOG2_DEPTH];
  end

  // Stage 2 next state: clear has priority, then an accepted sample, else hold.
  always_comb begin
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    sum_d        = sum_q;
    peak_d       = peak_q;
    fill_d       = fill_q;
    primed_d     = primed_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_d[i] = '0;
      end
      wr_ptr_d     = '0;
      sum_d        = '0;
      peak_d       = '0;
      fill_d       = '0;
      primed_d     = 1'b0;
      out_sample_d = '0;
      out_valid_d  = 1'b0;
    end else if (v1_q) begin
      buf_d[wr_ptr_q] = mag_q;
      wr_ptr_d        = wr_ptr_q + LOG2_DEPTH'(1);
      sum_d           = sum_next_s;
      peak_d          = peak_next_s;
      if (fill_q == FILL_MAX) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + (LOG2_DEPTH+1)'(1);
      end
      primed_d = (fill_d == FILL_MAX);
      if (mode) begin
        out_sample_d = peak_next_s;
      end else begin
        out_sample_d = avg_s;
      end
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Stage 2 registers, including the registered outputs.
  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      sum_q        <= '0;
      peak_q       <= '0;
      fill_q       <= '0;
      primed_q     <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      sum_q        <= sum_d;
      peak_q       <= peak_d;
      fill_q       <= fill_d;
      primed_q     <= primed_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower at W=8, LOG2_DEPTH=3, DECAY_SHIFT=2.
// A monitor collects every out_valid beat; each scenario lists the expected beats.

module tb_envelope_follower;

  logic       sample_clock = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       mode;
  logic       in_valid;
  logic [7:0] sample_in;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       primed;

  int n_checks = 0;
  int n_fail   = 0;

  int got_v[$];
  int got_p[$];
  int exp_v[$];
  int exp_p[$];

  int decay_seq[16] = '{12, 25, 37, 50, 62, 75, 87, 100, 87, 75, 62, 50, 37, 25, 12, 0};
  int peak_in[6]    = '{100, 0, 0, 0, 0, 90};
  int peak_seq[6]   = '{100, 75, 57, 43, 33, 90};

  envelope_follower #(
    .SAMPLE_WIDTH(8),
    .LOG2_DEPTH  (3),
    .DECAY_SHIFT (2)
  ) dut (
    .sample_clock(sample_clock),
    .rst_n       (rst_n),
    .clear       (clear),
    .mode        (mode),
    .in_valid    (in_valid),
    .sample_in   (sample_in),
    .out_valid   (out_valid),
    .out_sample  (out_sample),
    .primed      (primed)
  );

  always #5 sample_clock = ~sample_clock;

  // Collect every output beat just after the edge that produced it.
  always @(posedge sample_clock) begin
    #1;
    if (out_valid) begin
      got_v.push_back(int'(out_sample));
      got_p.push_back(int'(primed));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ex(input int v, input int p);
    exp_v.push_back(v);
    exp_p.push_back(p);
  endtask

  // Compare collected beats against the expected list, then reset both lists.
  task automatic check_seq(input string tag);
    check_val({tag, " beats"}, got_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i < got_v.size()) begin
        check_val($sformatf("%s out[%0d]", tag, i), got_v[i], exp_v[i]);
        check_val($sformatf("%s primed[%0d]", tag, i), got_p[i], exp_p[i]);
      end
    end
    got_v.delete(); got_p.delete();
    exp_v.delete(); exp_p.delete();
  endtask

  task automatic send(input logic [7:0] s, input logic m);
    @(negedge sample_clock);
    in_valid  = 1'b1;
    sample_in = s;
    mode      = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sample_clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge sample_clock);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge sample_clock);
    clear = 1'b0;
    got_v.delete(); got_p.delete();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; sample_in = 8'd0;
    repeat (2) @(posedge sample_clock);
    #1;
    check_val("reset out_sample", int'(out_sample), 0);
    check_val("reset out_valid", int'(out_valid), 0);
    check_val("reset primed", int'(primed), 0);
    @(negedge sample_clock);
    rst_n = 1'b1;

    // Step response, mode 0
    for (int i = 0; i < 8; i++) send(8'd64, 1'b0);
    idle(3);
    for (int i = 1; i <= 8; i++) ex(8 * i, (i == 8) ? 1 : 0);
    check_seq("step");

    // Rectification of -64 and of the most negative code
    do_clear();
    check_val("clear out_sample", int'(out_sample), 0);
    check_val("clear primed", int'(primed), 0);
    for (int i = 0; i < 8; i++) send(8'hC0, 1'b0);
    idle(3);
    for (int i = 1; i <= 8; i++) ex(8 * i, (i == 8) ? 1 : 0);
    check_seq("rect_neg64");
    do_clear();
    for (int i = 0; i < 8; i++) send(8'h80, 1'b0);
    idle(3);
    for (int i = 1; i <= 8; i++) ex(16 * i, (i == 8) ? 1 : 0);
    check_seq("rect_neg128");

    // Window wrap and release, back-to-back then gapped
    do_clear();
    for (int i = 0; i < 16; i++) send((i < 8) ? 8'd100 : 8'd0, 1'b0);
    idle(3);
    for (int i = 0; i < 16; i++) ex(decay_seq[i], (i >= 7) ? 1 : 0);
    check_seq("wrap");
    do_clear();
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? 8'd100 : 8'd0, 1'b0);
      idle(2);
    end
    idle(3);
    for (int i = 0; i < 16; i++) ex(decay_seq[i], (i >= 7) ? 1 : 0);
    check_seq("wrap_gapped");

    // Peak-hold with decay, then a fresh peak mid-decay
    do_clear();
    for (int i = 0; i < 6; i++) send(peak_in[i][7:0], 1'b1);
    idle(3);
    for (int i = 0; i < 6; i++) ex(peak_seq[i], 0);
    check_seq("peak");

    // Clear arriving with a valid sample while another sits in stage 1
    do_clear();
    send(8'd64, 1'b0);
    send(8'd64, 1'b0);
    @(negedge sample_clock);
    clear = 1'b1; in_valid = 1'b1; sample_in = 8'd64;
    @(negedge sample_clock);
    clear = 1'b0; in_valid = 1'b0;
    check_val("midclear out_sample", int'(out_sample), 0);
    check_val("midclear out_valid", int'(out_valid), 0);
    check_val("midclear primed", int'(primed), 0);
    idle(3);
    ex(8, 0);
    check_seq("midclear");

    // Latency: nothing after edge k, output after edge k+1
    send(8'd64, 1'b0);
    @(posedge sample_clock); #1;
    check_val("latency edge k valid", int'(out_valid), 0);
    @(negedge sample_clock);
    in_valid = 1'b0;
    @(posedge sample_clock); #1;
    check_val("latency edge k+1 valid", int'(out_valid), 1);
    check_val("latency edge k+1 out", int'(out_sample), 8);
    @(posedge sample_clock); #1;
    check_val("strobe one cycle", int'(out_valid), 0);
    check_val("hold out_sample", int'(out_sample), 8);
    got_v.delete(); got_p.delete();

    // Asynchronous reset mid-stream, away from any clock edge
    do_clear();
    for (int i = 0; i < 9; i++) send(8'd64, 1'b0);
    idle(3);
    check_val("pre-reset primed", int'(primed), 1);
    check_val("pre-reset out_sample", int'(out_sample), 64);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async reset out_sample", int'(out_sample), 0);
    check_val("async reset out_valid", int'(out_valid), 0);
    check_val("async reset primed", int'(primed), 0);
    #1;
    rst_n = 1'b1;
    got_v.delete(); got_p.delete();
    send(8'd80, 1'b0);
    idle(3);
    ex(10, 0);
    check_seq("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
